tcs_freq_meter: RTL and testbench

Frequency meter for the TCS-style color sensor `OUT` pin. It synchronizes the sensor's pulse train and counts rising edges over a fixed gate window after a filter-settle interval. It publishes the count on `frequency` with a one-cycle `begin_flag` strobe. It sits between the sensor pin and the color-decision block, which samples `frequency` on `begin_flag` and then switches the S2/S3 filter select before the next window starts.

---
 rtl/tcs_freq_meter.sv | 186 ++++++++++++++++++
 tb/tb_tcs_freq_meter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcs_freq_meter.sv
// tcs_freq_meter
// Frequency meter for the TCS-style color sensor OUT pin. The raw pulse train
// is synchronized, rising edges are detected, and after a settle interval the
// edges are counted over a fixed gate window. The count of each completed
// window is published on frequency together with a one-cycle begin_flag.
//
// Parameters
//   GATE_CYCLES   clock cycles per counting window (>= 2)
//   SETTLE_CYCLES cycles discarded after each publish or enable (>= 4)
//   CNT_W         width of the edge counter and of frequency
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   measurement enable; low forces IDLE
//   sensor_out  in   raw sensor pulse train, asynchronous to clock
//   frequency   out  rising-edge count of the last completed window
//   begin_flag  out  one-cycle strobe, frequency newly updated
//   overflow    out  last published count saturated
//   busy        out  high while settling or gating

module tcs_freq_meter #(
   parameter int GATE_CYCLES   = 1_000_000,
   parameter int SETTLE_CYCLES = 50_000,
   parameter int CNT_W         = 18
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             sensor_out,
   output logic [CNT_W-1:0] frequency,
   output logic             begin_flag,
   output logic             overflow,
   output logic             busy
);

   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GATE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             sync1;
   logic             sync2;
   logic             delayed;
   logic             rise;
   logic [SW-1:0]    settle_cnt;
   logic [GW-1:0]    win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             sat;
   logic             sat_next;
   logic             settle_done;
   logic             gate_done;
   logic             publish;

   // Two-flop synchronizer followed by a delay flop. All three reset low, so
   // a pin that is already high at reset release yields one detected edge;
   // that edge lands inside SETTLE and is discarded.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         delayed <= 1'b0;
      end else begin
         sync1   <= sensor_out;
         sync2   <= sync1;
         delayed <= sync2;
      end
   end

   assign rise        = sync2 & ~delayed;
   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign gate_done   = (win_cnt == GATE_LAST);

   // Saturating increment of the edge counter. Once an edge arrives while the
   // counter is already at full scale the sticky saturation bit is raised.
   always_comb begin
      cnt_next = edge_cnt;
      sat_next = sat;
      if (rise) begin
         if (edge_cnt == CNT_MAX) begin
            sat_next = 1'b1;
         end else begin
            cnt_next = edge_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic. Dropping enable always wins, including on the last
   // gate cycle, so a partial or just-completed window is never published.
   always_comb begin
      state_next = state;
      publish    = 1'b0;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = GATE;
            GATE: begin
               if (gate_done) begin
                  state_next = SETTLE;
                  publish    = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register; busy is registered alongside it so it follows the
   // state with no combinational path from enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // Settle and window counters plus the edge accumulator. The settle counter
   // is cleared whenever SETTLE is about to be (re)entered; the window
   // counter, edge counter and saturation bit are cleared on entry to GATE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         settle_cnt <= '0;
         win_cnt    <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               settle_cnt <= '0;
            end
            SETTLE: begin
               if (settle_done) begin
                  win_cnt  <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            GATE: begin
               win_cnt  <= win_cnt + GW'(1);
               edge_cnt <= cnt_next;
               sat      <= sat_next;
               if (gate_done) begin
                  settle_cnt <= '0;
               end
            end
            default: begin
               settle_cnt <= '0;
            end
         endcase
      end
   end

   // Published result. The final cycle's edge is folded in through cnt_next
   // so the window covers exactly GATE_CYCLES edge samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frequency  <= '0;
         overflow   <= 1'b0;
         begin_flag <= 1'b0;
      end else begin
         begin_flag <= publish;
         if (publish) begin
            frequency <= cnt_next;
            overflow  <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_tcs_freq_meter.sv
// tb_tcs_freq_meter
// Bench for tcs_freq_meter. Two instances share the same stimulus: one with an
// 18-bit counter and one with a 4-bit counter so saturation is observable.
// A behavioural model tracks the measurement timeline as plain arithmetic on
// the number of clock edges since enable, and a compare process checks every
// output of both instances on every falling edge. Directed scenarios add
// literal expectations that pin the model.

module tb_tcs_freq_meter;

   localparam int G = 100;
   localparam int S = 10;
   localparam int P = S + G;
   localparam int MAX18 = (1 << 18) - 1;
   localparam int MAX4  = (1 << 4) - 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic        sensor_out = 1'b0;
   logic [17:0] frequency;
   logic        begin_flag;
   logic        overflow;
   logic        busy;
   logic [3:0]  frequency4;
   logic        begin_flag4;
   logic        overflow4;
   logic        busy4;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   tcs_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(18)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .sensor_out (sensor_out),
      .frequency  (frequency),
      .begin_flag (begin_flag),
      .overflow   (overflow),
      .busy       (busy)
   );

   tcs_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut4 (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .sensor_out (sensor_out),
      .frequency  (frequency4),
      .begin_flag (begin_flag4),
      .overflow   (overflow4),
      .busy       (busy4)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Behavioural model. A rising edge of the sampled pin is credited three
   // clock edges after it is first sampled high. Counting t edges after the
   // edge that accepted enable, edges 1..S are settle, S+1..P are gate, and
   // the strobe follows edge P (and every P thereafter).
   bit h1, h2, h3;
   bit m_active;
   int m_t;
   int m_sum;
   int exp_freq, exp_freq4;
   bit exp_ovf, exp_ovf4, exp_flag, exp_busy;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h1 = 0; h2 = 0; h3 = 0;
         m_active = 0; m_t = 0; m_sum = 0;
         exp_freq = 0; exp_freq4 = 0;
         exp_ovf = 0; exp_ovf4 = 0; exp_flag = 0; exp_busy = 0;
      end else begin
         bit det;
         int pos;
         det = h2 && !h3;
         exp_flag = 0;
         if (!enable) begin
            m_active = 0;
         end else if (!m_active) begin
            m_active = 1;
            m_t = 0;
         end else begin
            m_t++;
            pos = (m_t - 1) % P;
            if (pos == S) m_sum = int'(det);
            else if (pos > S) m_sum += int'(det);
            if (pos == P - 1) begin
               exp_freq  = (m_sum > MAX18) ? MAX18 : m_sum;
               exp_ovf   = (m_sum > MAX18);
               exp_freq4 = (m_sum > MAX4) ? MAX4 : m_sum;
               exp_ovf4  = (m_sum > MAX4);
               exp_flag  = 1;
            end
         end
         exp_busy = m_active;
         h3 = h2; h2 = h1; h1 = sensor_out;
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: actual %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // Strobes of the 18-bit instance, indexed by the first edge that samples
   // begin_flag high.
   int st_cyc[$];
   int st_freq[$];
   int st_ovf[$];
   int st_freq4[$];
   int st_ovf4[$];

   always @(negedge clock) begin
      checkOutput("begin_flag", begin_flag, exp_flag);
      checkOutput("frequency", frequency, exp_freq);
      checkOutput("overflow", overflow, exp_ovf);
      checkOutput("busy", busy, exp_busy);
      checkOutput("begin_flag4", begin_flag4, exp_flag);
      checkOutput("frequency4", frequency4, exp_freq4);
      checkOutput("overflow4", overflow4, exp_ovf4);
      checkOutput("busy4", busy4, exp_busy);
      if (begin_flag) begin
         st_cyc.push_back(cyc + 1);
         st_freq.push_back(int'(frequency));
         st_ovf.push_back(int'(overflow));
         st_freq4.push_back(int'(frequency4));
         st_ovf4.push_back(int'(overflow4));
      end
   end

   // Drive sensor_out on n falling edges: per 0 holds low, per 1 is random
   // bits, otherwise a square wave high for the first half of each period.
   task automatic applyStimulus(input int n, input int per, input int ofs);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (per == 0) sensor_out = 1'b0;
         else if (per == 1) sensor_out = 1'($urandom_range(0, 1));
         else sensor_out = (((i + ofs) % per) < (per / 2));
      end
   endtask

   int n0;
   int e0;
   int e1;

   initial begin
      // Reset held with the pin toggling.
      #1 reset_n = 1'b0;
      applyStimulus(20, 1, 0);
      checkOutput("rst_frequency", frequency, 0);
      checkOutput("rst_begin_flag", begin_flag, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_busy", busy, 0);

      // Release with the pin high and enable low: idle for 1000 cycles.
      sensor_out = 1'b1;
      reset_n = 1'b1;
      n0 = st_cyc.size();
      applyStimulus(1000, 1, 0);
      checkOutput("idle_strobes", st_cyc.size() - n0, 0);
      checkOutput("idle_busy", busy, 0);

      // Nominal count: period 10, three windows.
      sensor_out = 1'b0;
      applyStimulus(5, 0, 0);
      enable = 1'b1;
      e0 = cyc + 1;
      n0 = st_cyc.size();
      applyStimulus(335, 10, 6);
      checkOutput("nom_strobes", st_cyc.size() - n0, 3);
      if (st_cyc.size() - n0 >= 3) begin
         checkOutput("nom_first", st_cyc[n0] - e0, 111);
         for (int k = 0; k < 3; k++) begin
            checkOutput("nom_freq", st_freq[n0 + k], 10);
            checkOutput("nom_ovf", st_ovf[n0 + k], 0);
         end
         checkOutput("nom_period1", st_cyc[n0 + 1] - st_cyc[n0], 110);
         checkOutput("nom_period2", st_cyc[n0 + 2] - st_cyc[n0 + 1], 110);
      end

      // Saturation: 25 edges per window, then 5 edges per window.
      applyStimulus(335, 4, 0);
      checkOutput("sat_freq4", st_freq4[$], 15);
      checkOutput("sat_ovf4", st_ovf4[$], 1);
      checkOutput("sat_freq18", st_freq[$], 25);
      checkOutput("sat_ovf18", st_ovf[$], 0);
      applyStimulus(335, 20, 0);
      checkOutput("unsat_freq4", st_freq4[$], 5);
      checkOutput("unsat_ovf4", st_ovf4[$], 0);

      // Settle masking: five pulses only inside SETTLE.
      enable = 1'b0;
      applyStimulus(5, 0, 0);
      enable = 1'b1;
      sensor_out = 1'b1;
      e0 = cyc + 1;
      n0 = st_cyc.size();
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         sensor_out = (i % 2 == 1);
      end
      applyStimulus(106, 0, 0);
      checkOutput("mask_strobes", st_cyc.size() - n0, 1);
      if (st_cyc.size() > n0) begin
         checkOutput("mask_first", st_cyc[n0] - e0, 111);
         checkOutput("mask_freq", st_freq[n0], 0);
      end

      // Enable drop 50 cycles into GATE after a publish of 10.
      enable = 1'b0;
      applyStimulus(5, 0, 0);
      enable = 1'b1;
      e0 = cyc + 1;
      n0 = st_cyc.size();
      applyStimulus(169, 10, 6);
      enable = 1'b0;
      applyStimulus(1, 10, 5);
      checkOutput("drop_busy", busy, 0);
      applyStimulus(200, 10, 0);
      checkOutput("drop_strobes", st_cyc.size() - n0, 1);
      checkOutput("drop_frequency", frequency, 10);
      enable = 1'b1;
      e1 = cyc + 1;
      n0 = st_cyc.size();
      applyStimulus(115, 10, 0);
      checkOutput("reen_strobes", st_cyc.size() - n0, 1);
      if (st_cyc.size() > n0) begin
         checkOutput("reen_first", st_cyc[n0] - e1, 111);
         checkOutput("reen_freq", st_freq[n0], 10);
      end

      // Randomized segments: random periods, random bits, enable toggling.
      for (int seg = 0; seg < 14; seg++) begin
         enable = ($urandom_range(0, 7) != 0);
         applyStimulus($urandom_range(100, 300), $urandom_range(1, 30), $urandom_range(0, 29));
      end

      // Asynchronous reset in the middle of GATE.
      enable = 1'b0;
      applyStimulus(5, 0, 0);
      enable = 1'b1;
      applyStimulus(171, 10, 6);
      checkOutput("pre_rst_frequency", frequency, 10);
      n0 = st_cyc.size();
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_frequency", frequency, 0);
      checkOutput("async_busy", busy, 0);
      checkOutput("async_begin_flag", begin_flag, 0);
      checkOutput("async_overflow", overflow, 0);
      applyStimulus(3, 10, 0);
      checkOutput("async_strobes", st_cyc.size() - n0, 0);
      reset_n = 1'b1;
      applyStimulus(20, 10, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
